reg_native_if_slv: RTL and testbench
====================================

REG_NATIVE_IF_SLV -- requirements
Module: reg_native_if_slv

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  BUS_DATA_WIDTH, 32, data width.
  BUS_ADDR_WIDTH, 48, byte address width.
  REG_NUM, 8, number of word registers (power of 2, 2..64).
  ACK_LATENCY, 2, cycles from the accepted req_vld to ack_vld (>=1).
  SECURE_REG_MASK, 8'h00, REG_NUM bits; bit i=1 makes reg i secure-only.
REQ-002 SHALL have ports (name, direction, width, meaning):
  native_clk  in  1  sole clock.
  native_rst_n  in  1  asynchronous active-low reset.
  soft_rst  in  1  synchronous soft reset pulse.
  req_vld  in  1  request pulse.
  addr  in  BUS_ADDR_WIDTH  byte address.
  wr_en  in  1  write request.
  rd_en  in  1  read request.
  wr_data  in  BUS_DATA_WIDTH  write data.
  non_sec  in  1  request is non-secure.
  ack_vld  out  1  one-cycle response pulse.
  err  out  1  error, valid with ack_vld.
  rd_data  out  BUS_DATA_WIDTH  read data, valid with ack_vld.
  reg_value  out  REG_NUM*BUS_DATA_WIDTH  flattened register contents, reg i at [i*DW +: DW].
  busy  out  1  transaction in flight.
  overrun  out  1  sticky flag, set when a request is dropped.
REQ-003 SHALL use one clock (native_clk) and an asynchronous active-low reset (native_rst_n); no other clock or reset input.

Function
REQ-004 FSM SHALL have states IDLE, WAIT, ACK; busy=1 in WAIT and ACK.
REQ-005 In IDLE, req_vld=1 SHALL capture addr, wr_en, rd_en, wr_data and non_sec, then go to ACK if ACK_LATENCY=1, else to WAIT with cnt=ACK_LATENCY-2.
REQ-006 WAIT SHALL decrement cnt each cycle and go to ACK on the cycle cnt=0; ACK SHALL last exactly one cycle, then return to IDLE.
REQ-007 Timing: req_vld in cycle T SHALL produce ack_vld=1 in cycle T+ACK_LATENCY only.
REQ-008 Back-to-back: a new req_vld SHALL be accepted no earlier than the cycle after ACK.
REQ-009 req_vld while not in IDLE SHALL be dropped, with no effect on the current transaction, and SHALL set overrun.
REQ-010 overrun SHALL stay set until soft_rst or reset.
REQ-011 Decode: an access is mapped iff addr[1:0]=0 and addr>>2 < REG_NUM; reg index=addr[2 +: log2(REG_NUM)].
REQ-012 err=1 with ack_vld SHALL be returned when any of the following holds:
  unmapped address;
  wr_en=rd_en (both or neither set);
  non_sec=1 targeting a reg whose SECURE_REG_MASK bit is set.
REQ-013 Erroneous accesses SHALL NOT modify any register; rd_data SHALL be 0.
REQ-014 A valid write SHALL update the register in the ACK cycle, visible on reg_value the next cycle; rd_data=0 for writes.
REQ-015 A valid read SHALL return the register value as sampled in the ACK cycle.
REQ-016 Outside the ACK cycle, ack_vld, err and rd_data SHALL all be 0.
REQ-017 soft_rst SHALL abort any transaction without issuing ack_vld, return the FSM to IDLE, clear overrun, and zero all registers.
REQ-018 soft_rst and req_vld in the same cycle: soft_rst wins, the request is dropped, and overrun is not set.

Reset
REQ-019 native_rst_n=0 SHALL asynchronously force: state IDLE, cnt 0, all registers 0, ack_vld 0, err 0, rd_data 0, busy 0, overrun 0.
REQ-020 A reset asserted mid-transaction SHALL discard the transaction; no ack_vld SHALL follow reset release.

Structure
REQ-021 The FSM state enum and error-cause constants SHALL live in shared package reg_native_if_pkg.
REQ-022 Register storage and write/read muxing SHALL be a single sub-module, reg_native_if_slv_regbank; FSM, counter and decode stay in the top module.

Verification (REG_NUM=8, ACK_LATENCY=3, SECURE_REG_MASK=8'h80)
REQ-023 Write addr=0x8, data=0xDEADBEEF at T -> ack_vld=1, err=0 at T+3; reg_value[2] becomes 0xDEADBEEF at T+4; read addr=0x8 returns 0xDEADBEEF.
REQ-024 Read addr=0x20 (unmapped), addr=0x6 (misaligned), and wr_en=rd_en=1 -> each returns ack at T+3 with err=1, rd_data=0, registers unchanged.
REQ-025 non_sec=1 write to addr=0x1C -> err=1, reg 7 unchanged; the same write with non_sec=0 -> err=0, reg 7 updated.
REQ-026 req_vld at T and again at T+1 -> exactly one ack_vld (T+3), overrun=1; soft_rst -> overrun=0, all regs 0.
REQ-027 soft_rst at T+1 after req_vld at T -> no ack_vld ever, busy=0 at T+2; the same abort via native_rst_n asserted at T+2 gives the same result.
REQ-028 ACK_LATENCY=1 build: three back-to-back requests at T, T+2, T+4 -> acks at T+1, T+3, T+5, overrun=0.

Source files
------------

// File: rtl/reg_native_if_pkg.sv
// rtl/reg_native_if_pkg.sv - shared FSM state and error-cause types for the native register slave
package reg_native_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Checked in this priority order; only "none" lets the access through.
  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_UNMAPPED    = 2'd1,
    ERR_RW_CONFLICT = 2'd2,
    ERR_SECURE      = 2'd3
  } err_cause_t;

endpackage

// File: rtl/reg_native_if_slv_regbank.sv
// rtl/reg_native_if_slv_regbank.sv - word register storage with single write port and read mux
module reg_native_if_slv_regbank #(
  parameter int DW      = 32,
  parameter int REG_NUM = 8,
  parameter int IDX_W   = $clog2(REG_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [DW-1:0]         i_wr_data,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic [DW-1:0]         o_rd_data,
  output logic [REG_NUM*DW-1:0] o_reg_value
);

  logic [DW-1:0] r_regs [REG_NUM];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_regs[i_rd_idx];

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign o_reg_value[g*DW +: DW] = r_regs[g];
  end

endmodule

// File: rtl/reg_native_if_slv.sv
// rtl/reg_native_if_slv.sv - native request/ack register slave with fixed ack latency and secure regs
module reg_native_if_slv
  import reg_native_if_pkg::*;
#(
  parameter int                 BUS_DATA_WIDTH  = 32,
  parameter int                 BUS_ADDR_WIDTH  = 48,
  parameter int                 REG_NUM         = 8,
  parameter int                 ACK_LATENCY     = 2,
  parameter logic [REG_NUM-1:0] SECURE_REG_MASK = {REG_NUM{1'b0}}
) (
  input  logic                              native_clk,
  input  logic                              native_rst_n,
  input  logic                              soft_rst,
  input  logic                              req_vld,
  input  logic [BUS_ADDR_WIDTH-1:0]         addr,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
  input  logic                              non_sec,
  output logic                              ack_vld,
  output logic                              err,
  output logic [BUS_DATA_WIDTH-1:0]         rd_data,
  output logic [REG_NUM*BUS_DATA_WIDTH-1:0] reg_value,
  output logic                              busy,
  output logic                              overrun
);

  localparam int IDX_W = $clog2(REG_NUM);
  localparam int CNT_W = (ACK_LATENCY > 2) ? $clog2(ACK_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((ACK_LATENCY > 1) ? ACK_LATENCY - 2 : 0);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BUS_ADDR_WIDTH-1:0] r_addr;
  logic                      r_wr_en;
  logic                      r_rd_en;
  logic [BUS_DATA_WIDTH-1:0] r_wr_data;
  logic                      r_non_sec;
  logic                      r_overrun;
  logic                      w_accept;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_mapped;
  err_cause_t                w_cause;
  logic                      w_ack;
  logic                      w_reg_wr;
  logic [BUS_DATA_WIDTH-1:0] w_rd_data;

  assign w_accept = (r_state == IDLE) && req_vld && !soft_rst;

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n)  r_state <= IDLE;
    else if (soft_rst)  r_state <= IDLE;
    else                r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_vld) w_next_state = (ACK_LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ack   = (r_state == ACK) && !soft_rst;
    ack_vld = w_ack;
    err     = w_ack && (w_cause != ERR_NONE);
    rd_data = (w_ack && (w_cause == ERR_NONE) && r_rd_en) ? w_rd_data : '0;
    busy    = (r_state != IDLE);
  end

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n)                          r_cnt <= '0;
    else if (soft_rst)                          r_cnt <= '0;
    else if (w_accept)                          r_cnt <= CNT_INIT;
    else if (r_state == WAIT && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n) begin
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_data <= '0;
      r_non_sec <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= addr;
      r_wr_en   <= wr_en;
      r_rd_en   <= rd_en;
      r_wr_data <= wr_data;
      r_non_sec <= non_sec;
    end
  end

  // Requests arriving while busy are dropped; soft_rst in the same cycle suppresses the flag.
  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n)                          r_overrun <= 1'b0;
    else if (soft_rst)                          r_overrun <= 1'b0;
    else if (req_vld && r_state != IDLE)        r_overrun <= 1'b1;
  end

  assign overrun = r_overrun;

  assign w_idx    = r_addr[2 +: IDX_W];
  assign w_mapped = (r_addr[1:0] == 2'b00) && (r_addr[BUS_ADDR_WIDTH-1:2+IDX_W] == '0);

  always_comb begin
    w_cause = ERR_NONE;
    if (!w_mapped)                                w_cause = ERR_UNMAPPED;
    else if (r_wr_en == r_rd_en)                  w_cause = ERR_RW_CONFLICT;
    else if (r_non_sec && SECURE_REG_MASK[w_idx]) w_cause = ERR_SECURE;
  end

  assign w_reg_wr = w_ack && (w_cause == ERR_NONE) && r_wr_en;

  reg_native_if_slv_regbank #(
    .DW      (BUS_DATA_WIDTH),
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W)
  ) u_regbank (
    .i_clk       (native_clk),
    .i_rst_n     (native_rst_n),
    .i_clr       (soft_rst),
    .i_wr_en     (w_reg_wr),
    .i_wr_idx    (w_idx),
    .i_wr_data   (r_wr_data),
    .i_rd_idx    (w_idx),
    .o_rd_data   (w_rd_data),
    .o_reg_value (reg_value)
  );

endmodule

// File: tb/tb_reg_native_if_slv.sv
// tb/tb_reg_native_if_slv.sv - self-checking bench for reg_native_if_slv (latency 3 and latency 1 builds)
module tb_reg_native_if_slv;

  localparam int DW  = 32;
  localparam int AW  = 48;
  localparam int RN  = 8;
  localparam int LAT = 3;
  localparam logic [RN-1:0] SEC_MASK = 8'h80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, soft_rst, req_vld, wr_en, rd_en, non_sec;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wr_data;
  logic           ack_vld, err, busy, overrun;
  logic [DW-1:0]  rd_data;
  logic [RN*DW-1:0] reg_value;

  logic           soft_rst1, req_vld1, wr_en1, rd_en1, non_sec1;
  logic [AW-1:0]  addr1;
  logic [DW-1:0]  wr_data1;
  logic           ack_vld1, err1, busy1, overrun1;
  logic [DW-1:0]  rd_data1;
  logic [RN*DW-1:0] reg_value1;

  reg_native_if_slv #(
    .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .REG_NUM(RN),
    .ACK_LATENCY(LAT), .SECURE_REG_MASK(SEC_MASK)
  ) dut (
    .native_clk(clk), .native_rst_n(rst_n), .soft_rst(soft_rst), .req_vld(req_vld),
    .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data), .non_sec(non_sec),
    .ack_vld(ack_vld), .err(err), .rd_data(rd_data), .reg_value(reg_value),
    .busy(busy), .overrun(overrun)
  );

  reg_native_if_slv #(
    .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .REG_NUM(RN),
    .ACK_LATENCY(1), .SECURE_REG_MASK(SEC_MASK)
  ) dut1 (
    .native_clk(clk), .native_rst_n(rst_n), .soft_rst(soft_rst1), .req_vld(req_vld1),
    .addr(addr1), .wr_en(wr_en1), .rd_en(rd_en1), .wr_data(wr_data1), .non_sec(non_sec1),
    .ack_vld(ack_vld1), .err(err1), .rd_data(rd_data1), .reg_value(reg_value1),
    .busy(busy1), .overrun(overrun1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: register contents plus the decode/permission rules.
  logic [DW-1:0] model [RN];

  function automatic void model_txn(input logic [AW-1:0] a, input bit w, input bit r,
                                    input logic [DW-1:0] d, input bit ns,
                                    output bit e, output logic [DW-1:0] rd);
    bit mapped;
    int idx;
    mapped = (a % 4 == 0) && ((a / 4) < AW'(RN));
    idx    = mapped ? int'(a / 4) : 0;
    e      = !mapped || (w == r) || (ns && SEC_MASK[idx]);
    rd     = '0;
    if (!e) begin
      if (w) model[idx] = d;
      else   rd = model[idx];
    end
  endfunction

  task automatic check_regs(input string name);
    for (int i = 0; i < RN; i++) chk(name, 64'(reg_value[i*DW +: DW]), 64'(model[i]));
  endtask

  task automatic clear_model();
    for (int i = 0; i < RN; i++) model[i] = '0;
  endtask

  // One transaction on the latency-3 DUT; ends at the negedge of cycle T+LAT+1.
  task automatic do_txn(input logic [AW-1:0] ta, input bit tw, input bit tr,
                        input logic [DW-1:0] td, input bit tns,
                        output bit got_err, output logic [DW-1:0] got_rd);
    int  ack_k = -1;
    int  n_ack = 0;
    bit  leak  = 1'b0;
    got_err = 1'b0;
    got_rd  = '0;
    @(negedge clk);
    addr = ta; wr_en = tw; rd_en = tr; wr_data = td; non_sec = tns; req_vld = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_vld = 1'b0;
        chk("busy_in_flight", 64'(busy), 64'd1);
      end
      if (ack_vld) begin
        n_ack++;
        ack_k   = k;
        got_err = err;
        got_rd  = rd_data;
      end else if (err || rd_data != '0) begin
        leak = 1'b1;
      end
    end
    chk("ack_count", 64'(n_ack), 64'd1);
    chk("ack_latency", 64'(ack_k), 64'(LAT));
    chk("idle_outputs_zero", 64'(leak), 64'd0);
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] a;
    bit            w;
    bit            r;
    logic [DW-1:0] d;
    bit            ns;
    bit            e;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit            ge, me;
    logic [DW-1:0] grd, mrd;
    int            n_ack;
    int            ack_k;
    bit            ok_err;

    vecs[0]  = '{"wr_08",      48'h8,            1, 0, 32'hDEADBEEF, 0, 0, 32'h0};
    vecs[1]  = '{"rd_08",      48'h8,            0, 1, 32'h0,        0, 0, 32'hDEADBEEF};
    vecs[2]  = '{"rd_20_unmap", 48'h20,          0, 1, 32'h0,        0, 1, 32'h0};
    vecs[3]  = '{"rd_06_misal", 48'h6,           0, 1, 32'h0,        0, 1, 32'h0};
    vecs[4]  = '{"rw_both",    48'h8,            1, 1, 32'h11111111, 0, 1, 32'h0};
    vecs[5]  = '{"rw_none",    48'h8,            0, 0, 32'h22222222, 0, 1, 32'h0};
    vecs[6]  = '{"ns_wr_1c",   48'h1C,           1, 0, 32'hBADBAD00, 1, 1, 32'h0};
    vecs[7]  = '{"wr_1c",      48'h1C,           1, 0, 32'hCAFEF00D, 0, 0, 32'h0};
    vecs[8]  = '{"ns_rd_1c",   48'h1C,           0, 1, 32'h0,        1, 1, 32'h0};
    vecs[9]  = '{"rd_1c",      48'h1C,           0, 1, 32'h0,        0, 0, 32'hCAFEF00D};
    vecs[10] = '{"ns_rd_08",   48'h8,            0, 1, 32'h0,        1, 0, 32'hDEADBEEF};
    vecs[11] = '{"rd_hi_unmap", 48'h1000_0000_0008, 0, 1, 32'h0,     0, 1, 32'h0};

    rst_n = 1'b0; soft_rst = 1'b0; req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    non_sec = 1'b0; addr = '0; wr_data = '0;
    soft_rst1 = 1'b0; req_vld1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
    non_sec1 = 1'b0; addr1 = '0; wr_data1 = '0;
    clear_model();

    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(ack_vld), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    check_regs("rst_regs");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].ns, ge, grd);
      chk({vecs[i].name, "_err"}, 64'(ge), 64'(vecs[i].e));
      chk({vecs[i].name, "_rd"}, 64'(grd), 64'(vecs[i].rd));
      model_txn(vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].d, vecs[i].ns, me, mrd);
      check_regs({vecs[i].name, "_regs"});
    end
    chk("reg2_deadbeef", 64'(reg_value[2*DW +: DW]), 64'hDEADBEEF);
    chk("reg7_cafef00d", 64'(reg_value[7*DW +: DW]), 64'hCAFEF00D);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] ra;
      bit rw, rr, rns;
      int op;
      logic [DW-1:0] rdat;
      ra = AW'($urandom_range(0, 39));
      if ($urandom_range(0, 7) == 0) ra = ra | {16'($urandom_range(1, 3)), 32'h0};
      op = $urandom_range(0, 7);
      rw = (op == 0) || (op >= 2 && op <= 4);
      rr = (op == 0) || (op >= 5);
      rns  = ($urandom_range(0, 3) == 0);
      rdat = $urandom;
      model_txn(ra, rw, rr, rdat, rns, me, mrd);
      do_txn(ra, rw, rr, rdat, rns, ge, grd);
      chk("rand_err", 64'(ge), 64'(me));
      chk("rand_rd", 64'(grd), 64'(mrd));
      check_regs("rand_regs");
    end

    // Overrun: second request one cycle later is dropped
    chk("overrun_pre", 64'(overrun), 64'd0);
    n_ack = 0; ack_k = -1; ok_err = 1'b1;
    @(negedge clk);
    addr = 48'h4; wr_en = 1; rd_en = 0; non_sec = 0; wr_data = 32'hA5A5A5A5; req_vld = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ack_vld) begin n_ack++; ack_k = k; ok_err = err; end
      if (k == 1) begin addr = 48'h0; wr_data = 32'h5A5A5A5A; end
      if (k == 2) req_vld = 0;
    end
    model_txn(48'h4, 1, 0, 32'hA5A5A5A5, 0, me, mrd);
    chk("ovr_ack_count", 64'(n_ack), 64'd1);
    chk("ovr_ack_latency", 64'(ack_k), 64'(LAT));
    chk("ovr_err", 64'(ok_err), 64'd0);
    chk("ovr_flag", 64'(overrun), 64'd1);
    check_regs("ovr_regs");
    do_txn(48'h10, 0, 1, 32'h0, 0, ge, grd);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    @(negedge clk); soft_rst = 1;
    @(negedge clk); soft_rst = 0;
    clear_model();
    chk("softrst_overrun", 64'(overrun), 64'd0);
    check_regs("softrst_regs");

    // soft_rst one cycle after the request aborts it
    do_txn(48'h10, 1, 0, 32'h00000077, 0, ge, grd);
    model_txn(48'h10, 1, 0, 32'h00000077, 0, me, mrd);
    n_ack = 0;
    @(negedge clk);
    addr = 48'h14; wr_en = 1; rd_en = 0; wr_data = 32'h12121212; req_vld = 1;
    @(negedge clk); req_vld = 0; soft_rst = 1;
    @(negedge clk); soft_rst = 0;
    chk("abort_soft_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack_vld) n_ack++; end
    chk("abort_soft_no_ack", 64'(n_ack), 64'd0);
    clear_model();
    check_regs("abort_soft_regs");

    // soft_rst coincident with req_vld wins
    n_ack = 0;
    @(negedge clk);
    addr = 48'h8; wr_en = 1; rd_en = 0; wr_data = 32'h34343434; req_vld = 1; soft_rst = 1;
    @(negedge clk); req_vld = 0; soft_rst = 0;
    chk("coincide_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack_vld) n_ack++; end
    chk("coincide_no_ack", 64'(n_ack), 64'd0);
    chk("coincide_overrun", 64'(overrun), 64'd0);
    check_regs("coincide_regs");

    // Hard reset at T+2 aborts the transaction
    do_txn(48'h14, 1, 0, 32'h00000099, 0, ge, grd);
    model_txn(48'h14, 1, 0, 32'h00000099, 0, me, mrd);
    check_regs("pre_hrst_regs");
    n_ack = 0;
    @(negedge clk);
    addr = 48'h18; wr_en = 1; rd_en = 0; wr_data = 32'h56565656; req_vld = 1;
    @(negedge clk); req_vld = 0;
    @(negedge clk); rst_n = 0;
    #1;
    chk("hrst_busy", 64'(busy), 64'd0);
    chk("hrst_ack", 64'(ack_vld), 64'd0);
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack_vld) n_ack++; end
    chk("hrst_no_ack", 64'(n_ack), 64'd0);
    clear_model();
    check_regs("hrst_regs");

    // Latency-1 build: requests at T, T+2, T+4 -> acks at T+1, T+3, T+5
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 1) chk($sformatf("lat1_ack_k%0d", k), 64'(ack_vld1), 64'((k == 1) || (k == 3) || (k == 5)));
      req_vld1 = (k == 0) || (k == 2) || (k == 4);
      addr1    = AW'(k * 2);
      wr_en1   = 1'b1;
      wr_data1 = 32'h100 + 32'(k);
    end
    req_vld1 = 1'b0;
    chk("lat1_overrun", 64'(overrun1), 64'd0);
    chk("lat1_reg0", 64'(reg_value1[0*DW +: DW]), 64'h100);
    chk("lat1_reg1", 64'(reg_value1[1*DW +: DW]), 64'h102);
    chk("lat1_reg2", 64'(reg_value1[2*DW +: DW]), 64'h104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
